// File: rtl/vga_pkg.sv
// Shared timing defaults (640x480@60), pattern-mode encodings and
// line/frame total helpers for the VGA raster engine.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef enum logic [1:0] {
    PAT_FB    = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_WHITE = 2'd3
  } pat_mode_t;

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register; every stage clears to zero, which is the
// inactive encoding for all fields carried through the alignment pipe.
module vga_delay_line #(
  parameter int W     = 8,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stages [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset) begin
      stages <= '{default: '0};
    end else begin
      stages[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster engine: h/v counters, framebuffer read requests,
// built-in test patterns, and sync/colour aligned to the read latency.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int RD_LAT   = 1,
  parameter int COLOR_W  = 8,
  parameter int X_W      = 10,
  parameter int Y_W      = 10
) (
  input  logic                 pclk,
  input  logic                 reset,
  input  logic [1:0]           pattern_sel,
  output logic                 rd_req,
  output logic [X_W-1:0]       rd_x,
  output logic [Y_W-1:0]       rd_y,
  input  logic [3*COLOR_W-1:0] rd_data,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 valid,
  output logic [COLOR_W-1:0]   vga_r,
  output logic [COLOR_W-1:0]   vga_g,
  output logic [COLOR_W-1:0]   vga_b,
  output logic                 frame_start,
  output logic                 line_start
);

  localparam int H_TOT = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOT = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int PW    = 3 * COLOR_W;
  localparam int DW    = PW + 6;

  localparam logic [X_W-1:0] H_LAST  = X_W'(H_TOT - 1);
  localparam logic [X_W-1:0] H_ACT_X = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] HS_BEG  = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0] HS_END  = X_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [Y_W-1:0] V_LAST  = Y_W'(V_TOT - 1);
  localparam logic [Y_W-1:0] V_ACT_Y = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] VS_BEG  = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0] VS_END  = Y_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic           HS_ON   = 1'(HS_POL);
  localparam logic           VS_ON   = 1'(VS_POL);

  logic [X_W-1:0] hc;
  logic [Y_W-1:0] vc;
  pat_mode_t      mode;
  pat_mode_t      mode_eff;
  logic           frame_origin;

  // The frame's first pixel already uses the newly sampled mode, so every
  // pixel of a frame sees one consistent mode.
  assign frame_origin = (hc == '0) && (vc == '0);
  assign mode_eff     = frame_origin ? pat_mode_t'(pattern_sel) : mode;

  always_ff @(posedge pclk) begin
    if (!reset) begin
      hc   <= '0;
      vc   <= '0;
      mode <= PAT_FB;
    end else begin
      if (frame_origin) mode <= pat_mode_t'(pattern_sel);
      if (hc == H_LAST) begin
        hc <= '0;
        vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
      end else begin
        hc <= hc + 1'b1;
      end
    end
  end

  logic act, hs_raw, vs_raw, line_flag, use_fb;
  assign act       = (hc < H_ACT_X) && (vc < V_ACT_Y);
  assign hs_raw    = (hc >= HS_BEG) && (hc <= HS_END);
  assign vs_raw    = (vc >= VS_BEG) && (vc <= VS_END);
  assign line_flag = (hc == '0) && (vc < V_ACT_Y);
  assign use_fb    = (mode_eff == PAT_FB);

  // Read contract: rd_req is a one-cycle strobe with no backpressure; the
  // framebuffer must present rd_data exactly RD_LAT cycles after the strobe.
  assign rd_req = act && use_fb;
  assign rd_x   = act ? hc : '0;
  assign rd_y   = act ? vc : '0;

  logic [2:0]    bar;
  logic [PW-1:0] pat_rgb;

  // Threshold compare instead of a divide; columns past 8 full bars stay on bar 7.
  always_comb begin
    bar = '0;
    for (int i = 1; i < 8; i++) begin
      if (hc >= X_W'(i * (H_ACTIVE / 8))) bar = 3'(i);
    end
  end

  always_comb begin
    pat_rgb = '0;
    case (mode_eff)
      PAT_BARS:  pat_rgb = {{COLOR_W{bar[2]}}, {COLOR_W{bar[1]}}, {COLOR_W{bar[0]}}};
      PAT_CHECK: pat_rgb = {PW{hc[5] ^ vc[5]}};
      PAT_WHITE: pat_rgb = '1;
      default:   pat_rgb = '0;
    endcase
  end

  logic [DW-1:0] pipe_d, pipe_q;
  assign pipe_d = {act, hs_raw, vs_raw, frame_origin, line_flag, use_fb, pat_rgb};

  vga_delay_line #(
    .W     (DW),
    .DEPTH (RD_LAT)
  ) u_align (
    .clk   (pclk),
    .reset (reset),
    .d     (pipe_d),
    .q     (pipe_q)
  );

  logic          d_act, d_hs, d_vs, d_fs, d_ls, d_fb;
  logic [PW-1:0] d_rgb;
  assign {d_act, d_hs, d_vs, d_fs, d_ls, d_fb, d_rgb} = pipe_q;

  always_ff @(posedge pclk) begin
    if (!reset) begin
      hsync       <= ~HS_ON;
      vsync       <= ~VS_ON;
      valid       <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      {vga_r, vga_g, vga_b} <= '0;
    end else begin
      hsync       <= d_hs ? HS_ON : ~HS_ON;
      vsync       <= d_vs ? VS_ON : ~VS_ON;
      valid       <= d_act;
      frame_start <= d_fs;
      line_start  <= d_ls;
      {vga_r, vga_g, vga_b} <= d_act ? (d_fb ? rd_data : d_rgb) : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a 640x480 instance checked against a vector
// table, and a small-raster instance (RD_LAT=3, positive syncs) for frame-level cases.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- instance 0: default timing ----------------
  logic        rst0 = 1'b0;
  logic [1:0]  sel0 = 2'd0;
  logic        rd_req0, hs0, vs0, valid0, fs0, ls0;
  logic [9:0]  rd_x0, rd_y0;
  logic [23:0] rd_data0 = '0;
  logic [7:0]  r0, g0, b0;
  logic [23:0] rgb0;
  assign rgb0 = {r0, g0, b0};

  vga_timing_gen u0 (
    .pclk(clk), .reset(rst0), .pattern_sel(sel0),
    .rd_req(rd_req0), .rd_x(rd_x0), .rd_y(rd_y0), .rd_data(rd_data0),
    .hsync(hs0), .vsync(vs0), .valid(valid0),
    .vga_r(r0), .vga_g(g0), .vga_b(b0),
    .frame_start(fs0), .line_start(ls0)
  );

  always @(posedge clk) rd_data0 <= rd_req0 ? {rd_x0[7:0], rd_y0[7:0], 8'h5A} : 24'hC3C3C3;

  // ---------------- instance 1: small raster 80x48 ----------------
  localparam int FR1 = 3840;
  logic        rst1 = 1'b0;
  logic [1:0]  sel1 = 2'd0;
  logic        rd_req1, hs1, vs1, valid1, fs1, ls1;
  logic [6:0]  rd_x1;
  logic [5:0]  rd_y1;
  logic [23:0] p1 = '0, p2 = '0, rd_data1 = '0;
  logic [7:0]  r1, g1, b1;
  logic [23:0] rgb1;
  assign rgb1 = {r1, g1, b1};

  vga_timing_gen #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(40), .V_FP(2), .V_SYNC(3), .V_BP(3),
    .HS_POL(1), .VS_POL(1), .RD_LAT(3), .COLOR_W(8), .X_W(7), .Y_W(6)
  ) u1 (
    .pclk(clk), .reset(rst1), .pattern_sel(sel1),
    .rd_req(rd_req1), .rd_x(rd_x1), .rd_y(rd_y1), .rd_data(rd_data1),
    .hsync(hs1), .vsync(vs1), .valid(valid1),
    .vga_r(r1), .vga_g(g1), .vga_b(b1),
    .frame_start(fs1), .line_start(ls1)
  );

  always @(posedge clk) begin
    p1       <= rd_req1 ? {1'b0, rd_x1, 2'b00, rd_y1, 8'h5A} : 24'hC3C3C3;
    p2       <= p1;
    rd_data1 <= p2;
  end

  // Cycle k = k-th cycle after reset release; cycle 0 has counters at 0,0.
  int cyc0 = 0, cyc1 = 0;
  always @(posedge clk) begin
    if (!rst0) cyc0 <= 0; else cyc0 <= cyc0 + 1;
    if (!rst1) cyc1 <= 0; else cyc1 <= cyc1 + 1;
  end

  // ---------------- frame statistics for instance 1 ----------------
  logic tally_en = 1'b0;
  int   v_cnt [4], hs_cnt [4], vs_cnt [4], ls_cnt [4], rd_cnt [4];
  int   fs_q [$];
  int   first_vs = -1;

  initial begin
    for (int i = 0; i < 4; i++) begin
      v_cnt[i] = 0; hs_cnt[i] = 0; vs_cnt[i] = 0; ls_cnt[i] = 0; rd_cnt[i] = 0;
    end
  end

  always @(negedge clk) begin
    if (rst1 && tally_en) begin
      if (cyc1 < 4 * FR1) rd_cnt[cyc1 / FR1] += int'(rd_req1);
      if (cyc1 >= 4 && cyc1 < 4 + 4 * FR1) begin
        v_cnt[(cyc1 - 4) / FR1]  += int'(valid1);
        hs_cnt[(cyc1 - 4) / FR1] += int'(hs1);
        vs_cnt[(cyc1 - 4) / FR1] += int'(vs1);
        ls_cnt[(cyc1 - 4) / FR1] += int'(ls1);
      end
      if (fs1) fs_q.push_back(cyc1);
      if (vs1 && first_vs < 0) first_vs = cyc1;
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic wait_cyc0(input int t);
    while (cyc0 < t) @(negedge clk);
    if (cyc0 != t) check("late_wait0", cyc0, t);
  endtask

  task automatic wait_cyc1(input int t);
    while (cyc1 < t) @(negedge clk);
    if (cyc1 != t) check("late_wait1", cyc1, t);
  endtask

  task automatic pix1(input string name, input int t, input logic v, input logic [23:0] rgb);
    wait_cyc1(t);
    check({name, "_valid"}, valid1, v);
    check({name, "_rgb"}, rgb1, rgb);
  endtask

  typedef struct {
    int          cyc;
    logic        valid, hs, vs, fs, ls;
    logic [23:0] rgb;
  } vec_t;

  function automatic vec_t mk(input int c, input logic v, input logic h, input logic s,
                              input logic f, input logic l, input logic [23:0] rgb);
    vec_t r;
    r.cyc = c; r.valid = v; r.hs = h; r.vs = s; r.fs = f; r.ls = l; r.rgb = rgb;
    return r;
  endfunction

  vec_t vecs [17];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    //              cyc  val hs vs fs ls rgb
    vecs[0]  = mk(1,    0, 1, 1, 0, 0, 24'h000000);
    vecs[1]  = mk(2,    1, 1, 1, 1, 1, 24'h00005A);
    vecs[2]  = mk(3,    1, 1, 1, 0, 0, 24'h01005A);
    vecs[3]  = mk(7,    1, 1, 1, 0, 0, 24'h05005A);
    vecs[4]  = mk(257,  1, 1, 1, 0, 0, 24'hFF005A);
    vecs[5]  = mk(258,  1, 1, 1, 0, 0, 24'h00005A);
    vecs[6]  = mk(641,  1, 1, 1, 0, 0, 24'h7F005A);
    vecs[7]  = mk(642,  0, 1, 1, 0, 0, 24'h000000);
    vecs[8]  = mk(657,  0, 1, 1, 0, 0, 24'h000000);
    vecs[9]  = mk(658,  0, 0, 1, 0, 0, 24'h000000);
    vecs[10] = mk(753,  0, 0, 1, 0, 0, 24'h000000);
    vecs[11] = mk(754,  0, 1, 1, 0, 0, 24'h000000);
    vecs[12] = mk(801,  0, 1, 1, 0, 0, 24'h000000);
    vecs[13] = mk(802,  1, 1, 1, 0, 1, 24'h00015A);
    vecs[14] = mk(1457, 0, 1, 1, 0, 0, 24'h000000);
    vecs[15] = mk(1458, 0, 0, 1, 0, 0, 24'h000000);
    vecs[16] = mk(1607, 1, 1, 1, 0, 0, 24'h05025A);

    // Reset state of both instances.
    repeat (3) @(negedge clk);
    check("rst0_hsync", hs0, 1'b1);
    check("rst0_vsync", vs0, 1'b1);
    check("rst0_valid", valid0, 1'b0);
    check("rst0_rgb", rgb0, 24'h0);
    check("rst0_fs", fs0, 1'b0);
    check("rst0_ls", ls0, 1'b0);
    check("rst1_hsync", hs1, 1'b0);
    check("rst1_vsync", vs1, 1'b0);

    @(posedge clk); #2; rst0 = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wait_cyc0(vecs[i].cyc);
      check($sformatf("v%0d_valid", i), valid0, vecs[i].valid);
      check($sformatf("v%0d_hsync", i), hs0, vecs[i].hs);
      check($sformatf("v%0d_vsync", i), vs0, vecs[i].vs);
      check($sformatf("v%0d_fs", i), fs0, vecs[i].fs);
      check($sformatf("v%0d_ls", i), ls0, vecs[i].ls);
      check($sformatf("v%0d_rgb", i), rgb0, vecs[i].rgb);
    end

    // Instance 1: latency 3, framebuffer frames 0 and 1.
    @(posedge clk); #2; rst1 = 1'b1; tally_en = 1'b1;
    pix1("l3_c3", 3, 1'b0, 24'h0);
    check("l3_c3_fs", fs1, 1'b0);
    pix1("l3_first", 4, 1'b1, 24'h00005A);
    check("l3_first_fs", fs1, 1'b1);
    check("l3_first_ls", ls1, 1'b1);
    pix1("l3_x4y7", 568, 1'b1, 24'h04075A);
    pix1("l3_x5y7", 569, 1'b1, 24'h05075A);

    wait_cyc1(FR1 + 1000); sel1 = 2'd1;
    pix1("latch_x8y20", FR1 + 1608 + 4, 1'b1, 24'h08145A);
    pix1("latch_x63y39", FR1 + 3183 + 4, 1'b1, 24'h3F275A);

    // Frame 2: colour bars, 8 pixels per bar.
    pix1("bars_origin", 2 * FR1 + 4, 1'b1, 24'h000000);
    check("bars_origin_fs", fs1, 1'b1);
    pix1("bars_x0",  2 * FR1 + 244, 1'b1, 24'h000000);
    pix1("bars_x8",  2 * FR1 + 252, 1'b1, 24'h0000FF);
    pix1("bars_x15", 2 * FR1 + 259, 1'b1, 24'h0000FF);
    pix1("bars_x16", 2 * FR1 + 260, 1'b1, 24'h00FF00);
    pix1("bars_x20", 2 * FR1 + 264, 1'b1, 24'h00FF00);
    pix1("bars_x44", 2 * FR1 + 288, 1'b1, 24'hFF00FF);
    pix1("bars_x63", 2 * FR1 + 307, 1'b1, 24'hFFFFFF);
    pix1("bars_x64", 2 * FR1 + 308, 1'b0, 24'h000000);
    wait_cyc1(2 * FR1 + 3000); sel1 = 2'd2;
    pix1("bars_x8y39", 2 * FR1 + 3128 + 4, 1'b1, 24'h0000FF);

    // Frame 3: checkerboard.
    pix1("chk_0_0",   3 * FR1 + 4, 1'b1, 24'h000000);
    pix1("chk_31_0",  3 * FR1 + 35, 1'b1, 24'h000000);
    pix1("chk_32_0",  3 * FR1 + 36, 1'b1, 24'hFFFFFF);
    pix1("chk_blank", 3 * FR1 + 74, 1'b0, 24'h000000);
    pix1("chk_0_32",  3 * FR1 + 2564, 1'b1, 24'hFFFFFF);
    pix1("chk_32_32", 3 * FR1 + 2596, 1'b1, 24'h000000);
    wait_cyc1(3 * FR1 + 3300); sel1 = 2'd3;

    // Frame 4: solid white.
    pix1("white_10_10", 4 * FR1 + 814, 1'b1, 24'hFFFFFF);
    pix1("white_blank", 4 * FR1 + 870, 1'b0, 24'h000000);
    tally_en = 1'b0;

    for (int f = 0; f < 4; f++) begin
      check($sformatf("f%0d_valid_cnt", f), v_cnt[f], 2560);
      check($sformatf("f%0d_hsync_cnt", f), hs_cnt[f], 288);
      check($sformatf("f%0d_vsync_cnt", f), vs_cnt[f], 240);
      check($sformatf("f%0d_ls_cnt", f), ls_cnt[f], 40);
      check($sformatf("f%0d_rd_cnt", f), rd_cnt[f], (f < 2) ? 2560 : 0);
    end
    check("first_vsync", first_vs, 3364);
    check("fs_count", fs_q.size(), 5);
    if (fs_q.size() > 0) check("fs_first", fs_q[0], 4);
    for (int i = 1; i < fs_q.size(); i++)
      check($sformatf("fs_period%0d", i), fs_q[i] - fs_q[i-1], FR1);

    // Mid-line reset while hsync is asserted on line 20.
    sel1 = 2'd0;
    wait_cyc1(4 * FR1 + 1673);
    check("pre_rst_hsync", hs1, 1'b1);
    rst1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("mid_rst%0d_hsync", k), hs1, 1'b0);
      check($sformatf("mid_rst%0d_vsync", k), vs1, 1'b0);
      check($sformatf("mid_rst%0d_valid", k), valid1, 1'b0);
      check($sformatf("mid_rst%0d_rgb", k), rgb1, 24'h0);
    end
    @(posedge clk); #2; rst1 = 1'b1;
    pix1("restart_c3", 3, 1'b0, 24'h0);
    check("restart_c3_fs", fs1, 1'b0);
    pix1("restart_c4", 4, 1'b1, 24'h00005A);
    check("restart_c4_fs", fs1, 1'b1);
    check("restart_c4_ls", ls1, 1'b1);
    check("restart_c4_vsync", vs1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster engine, successor to the fixed 640x480 scanner.
- Generates programmable h/v timing and sync polarity.
- Issues pixel read requests to an external framebuffer with configurable read latency; aligns sync/valid/colour to the returned data.
- Adds frame-latched built-in test-pattern modes; sits between the framebuffer/display memory and the board VGA pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- HS_POL, 0, hsync asserted level (0 = active-low)
- VS_POL, 0, vsync asserted level
- RD_LAT, 1, framebuffer read latency in cycles (>=1)
- COLOR_W, 8, bits per colour channel
- X_W, 10, width of x coordinate/counter (must hold H total - 1)
- Y_W, 10, width of y coordinate/counter (must hold V total - 1)

Ports:
- pclk, in, 1, pixel clock
- reset, in, 1, synchronous active-low reset
- pattern_sel, in, 2, 0 = framebuffer, 1 = colour bars, 2 = checkerboard, 3 = solid white
- rd_req, out, 1, framebuffer read strobe
- rd_x, out, X_W, requested pixel x (0-based)
- rd_y, out, Y_W, requested pixel y
- rd_data, in, 3*COLOR_W, {r,g,b} returned exactly RD_LAT cycles after rd_req
- hsync, out, 1, horizontal sync
- vsync, out, 1, vertical sync
- valid, out, 1, active-video qualifier
- vga_r, out, COLOR_W, red
- vga_g, out, COLOR_W, green
- vga_b, out, COLOR_W, blue
- frame_start, out, 1, one-cycle pulse aligned with first active pixel of frame
- line_start, out, 1, one-cycle pulse aligned with first active pixel of each active line

Behaviour:
- Line/frame ordering: active, FP, SYNC, BP.
  - H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP.
  - V_TOT is defined likewise from the vertical parameters.
- Counters hc (0..H_TOT-1) and vc (0..V_TOT-1), 0-based.
  - hc increments every cycle and wraps to 0 after H_TOT-1.
  - On hc wrap, vc increments and wraps to 0 after V_TOT-1.
- Stage-0 decodes (combinational from counters):
  - act = (hc < H_ACTIVE) & (vc < V_ACTIVE)
  - hs_raw = hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]
  - vs_raw = vc in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]
- Read interface:
  - rd_req = act & (mode == 0).
  - rd_x = hc and rd_y = vc when act, else 0.
  - No backpressure: rd_data is assumed valid RD_LAT cycles later.
- Alignment: act, hs_raw, vs_raw, the pattern colour and the frame/line-start flags pass through a delay pipeline of RD_LAT stages, then one output register stage.
  - Total latency from counter value to pins = RD_LAT+1 cycles.
  - rd_data is registered once into the output stage.
- Outputs:
  - hsync = HS_POL when delayed hs_raw is set, else ~HS_POL.
  - vsync is driven the same way from delayed vs_raw and VS_POL.
- Colour:
  - When delayed act = 0, RGB = 0 (forced blank).
  - Otherwise, mode 0 uses rd_data; modes 1-3 use the pattern colour generated at stage 0 from hc/vc.
- Patterns:
  - Colour bars: 8 equal bars, bar = hc / (H_ACTIVE/8) (integer divide; the remainder columns take bar 7). Bar b gives r = {COLOR_W{b[2]}}, g = {COLOR_W{b[1]}}, b = {COLOR_W{b[0]}}, i.e. bar 0 = black, bar 7 = white.
  - Checkerboard: white if hc[5]^vc[5], else black.
  - Solid white: all channels all-ones.
- Mode latch: pattern_sel is sampled into mode only on the cycle hc=0, vc=0, so a mid-frame change takes effect next frame. Reset loads mode = 0.
- Pulses:
  - frame_start is asserted when the delayed flag (hc=0 & vc=0) is set.
  - line_start is asserted when the delayed flag (hc=0 & vc<V_ACTIVE) is set.
  - Both are single cycle.
- Reset (reset=0 at a pclk edge):
  - hc=0, vc=0, and all pipeline stages cleared to the inactive state.
  - Pin values: hsync=~HS_POL, vsync=~VS_POL, valid=0, RGB=0, pulses 0.
  - Mid-frame reset restarts the frame; there is no partial-line continuation.
- On the first cycle after reset release, the counters are at 0,0; valid/frame_start first rise RD_LAT+1 cycles later.

Decomposition:
- Package vga_pkg holds:
  - the timing-parameter defaults (640x480@60 set);
  - the pattern mode encodings: PAT_FB, PAT_BARS, PAT_CHECK, PAT_WHITE;
  - helper functions for H_TOT/V_TOT.
- One natural sub-module: vga_delay_line, a parametrised width/depth shift register used for the RD_LAT alignment pipeline.

Test Plan:
- Defaults, release reset at cycle 0, rd_data = {x[7:0], y[7:0], 8'h5A} model with RD_LAT=1 -> at cycle 2:
  - valid=1, frame_start=1, RGB = 00_00_5A;
  - valid falls at cycle 642;
  - hsync low for exactly cycles 658..753;
  - period 800 cycles.
- Full frame count -> frame_start period 420000 cycles; vsync low for 1600 cycles starting on line 490; valid high for 640*480 = 307200 cycles per frame.
- RD_LAT=3, same data model -> first valid at cycle 4; pixel (x=5, y=7) appears with RGB = 05_07_5A exactly when valid is set and the 6th pixel of line 7 is on the pins.
- pattern_sel=1 applied mid-frame -> no change until next frame_start. Then columns 0..79 black, 80..159 blue (0000FF), ..., 560..639 white; rd_req stays 0 all frame.
- pattern_sel=2 -> pixel (32,0) white, (32,32) black, (0,0) black; blanking RGB = 0.
- HS_POL=1, VS_POL=1, reset asserted mid-line 100 for 3 cycles -> during reset hsync=0, vsync=0, valid=0; after release, counters restart and frame_start occurs RD_LAT+1 cycles later.
